alu_sliced: RTL and testbench

- Multi-cycle WIDTH-bit ALU that processes operands in SLICE-bit digits, least-significant digit first.
- Carry is registered between digits, so a wide ALU costs one SLICE-wide datapath plus NSLICE = WIDTH/SLICE cycles.
- Uses the same 3-bit ctrl encoding as the single-bit ALU slice and adds a valid/ready handshake and registered status flags.
- Sits between the register-read stage and writeback, as the area-optimised ALU option.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_digit.sv | 38 +++
 rtl/alu_sliced.sv | 144 ++++++++++++++
 tb/tb_alu_sliced.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: ctrl encoding, FSM states and sizing helpers.
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_digit.sv
// One SLICE-bit digit of the ALU; subtract is A + ~B + cin, logic ops use raw B.
module alu_digit
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [2:0]       ctrl,
    output logic [SLICE-1:0] out,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE-1:0] w_b_add;
    logic [SLICE:0]   w_sum;

    assign w_b_add = b ^ {SLICE{ctrl[0]}};
    assign w_sum   = {1'b0, a} + {1'b0, w_b_add} + {{SLICE{1'b0}}, cin};
    assign cout    = w_sum[SLICE];
    // Recover the carry into the MSB from the MSB sum bit and its operands.
    assign cmsb    = a[SLICE-1] ^ w_b_add[SLICE-1] ^ w_sum[SLICE-1];

    always_comb begin
        out = '0;
        case (ctrl)
            ALU_PASS_B:   out = b;
            ALU_ADD:      out = w_sum[SLICE-1:0];
            ALU_SUBTRACT: out = w_sum[SLICE-1:0];
            ALU_AND:      out = a & b;
            ALU_OR:       out = a | b;
            ALU_XOR:      out = a ^ b;
            default:      out = '0;
        endcase
    end

endmodule

// File: rtl/alu_sliced.sv
// Digit-serial WIDTH-bit ALU, LS digit first, with registered carry and valid/ready handshake.
// States: IDLE accept operands | RUN one digit per clock | DONE hold result until out_ready.
module alu_sliced
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int CW     = cnt_width(NSLICE);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_ctrl;
    logic             r_carry;
    logic             r_zero_acc;
    logic             r_zero;
    logic             r_ovf;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic [31:0]      w_base;
    logic [SLICE-1:0] w_a_dig;
    logic [SLICE-1:0] w_b_dig;
    logic [SLICE-1:0] w_out;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_last;
    logic             w_accept;
    logic             w_arith;
    logic             w_dig_zero;

    assign w_base     = 32'(r_cnt) * 32'(SLICE);
    assign w_a_dig    = r_a[w_base +: SLICE];
    assign w_b_dig    = r_b[w_base +: SLICE];
    assign w_last     = (r_cnt == CW'(NSLICE - 1));
    assign w_accept   = in_valid & in_ready;
    assign w_arith    = (r_ctrl == ALU_ADD) || (r_ctrl == ALU_SUBTRACT);
    assign w_dig_zero = (w_out == '0);

    alu_digit #(.SLICE(SLICE)) u_digit (
        .a    (w_a_dig),
        .b    (w_b_dig),
        .cin  (r_carry),
        .ctrl (r_ctrl),
        .out  (w_out),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~reset;
                if (w_accept) w_next = RUN;
            end
            RUN: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_ctrl     <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_zero_acc <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_cout     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a        <= A;
                        r_b        <= B;
                        r_ctrl     <= ctrl;
                        r_carry    <= ctrl[0];
                        r_cnt      <= '0;
                        r_zero_acc <= 1'b1;
                    end
                end
                RUN: begin
                    r_result[w_base +: SLICE] <= w_out;
                    r_carry    <= w_cout;
                    r_zero_acc <= r_zero_acc & w_dig_zero;
                    r_cnt      <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_zero <= r_zero_acc & w_dig_zero;
                        r_ovf  <= w_arith & (w_cmsb ^ w_cout);
                        r_cout <= w_arith & w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign negative  = r_result[WIDTH-1];
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign carry_out = r_cout;

endmodule

// File: tb/tb_alu_sliced.sv
// Directed bench for alu_sliced with SLICE = 8, 1 and 64 instances sharing operands.
module tb_alu_sliced;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic [2:0]  ctrl = '0;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [63:0] res       [3];
    logic        neg       [3];
    logic        zro       [3];
    logic        ovf       [3];
    logic        cout      [3];

    int n_vec  = 0;
    int n_miss = 0;
    int lat [3] = '{8, 64, 1};

    always #5 clk = ~clk;

    alu_sliced #(.WIDTH(64), .SLICE(8)) u_s8 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(A), .B(B), .ctrl(ctrl), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .result(res[0]), .negative(neg[0]), .zero(zro[0]), .overflow(ovf[0]), .carry_out(cout[0]));

    alu_sliced #(.WIDTH(64), .SLICE(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(A), .B(B), .ctrl(ctrl), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .result(res[1]), .negative(neg[1]), .zero(zro[1]), .overflow(ovf[1]), .carry_out(cout[1]));

    alu_sliced #(.WIDTH(64), .SLICE(64)) u_s64 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(A), .B(B), .ctrl(ctrl), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .result(res[2]), .negative(neg[2]), .zero(zro[2]), .overflow(ovf[2]), .carry_out(cout[2]));

    typedef struct {
        logic [2:0]  c;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        n;
        logic        z;
        logic        v;
        logic        co;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input int d, input string tag, input logic [2:0] c,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic en, input logic ez,
                         input logic ev, input logic eco);
        int cyc;
        @(negedge clk);
        A = a; B = b; ctrl = c;
        in_valid[d] = 1'b1;
        chk({tag, " in_ready"}, 64'(in_ready[d]), 64'd1);
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (out_valid[d]) begin
                cyc = i;
                break;
            end
        end
        chk({tag, " latency"}, 64'(cyc), 64'(lat[d]));
        chk({tag, " result"}, res[d], er);
        chk({tag, " negative"}, 64'(neg[d]), 64'(en));
        chk({tag, " zero"}, 64'(zro[d]), 64'(ez));
        chk({tag, " overflow"}, 64'(ovf[d]), 64'(ev));
        chk({tag, " carry_out"}, 64'(cout[d]), 64'(eco));
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1 out_ready[d] = 1'b0;
        chk({tag, " out_valid drop"}, 64'(out_valid[d]), 64'd0);
        chk({tag, " back to idle"}, 64'(in_ready[d]), 64'd1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end

        vecs[0]  = '{ALU_ADD,      64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1, 0, 1, 0};
        vecs[1]  = '{ALU_SUBTRACT, 64'd5, 64'd5, 64'h0, 0, 1, 0, 1};
        vecs[2]  = '{ALU_SUBTRACT, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0};
        vecs[3]  = '{ALU_AND,      64'hF0F0_1234_0000_FFFF, 64'h0FF0_FFFF_8000_00FF, 64'h00F0_1234_0000_00FF, 0, 0, 0, 0};
        vecs[4]  = '{ALU_OR,       64'hF0F0_1234_0000_FFFF, 64'h0FF0_FFFF_8000_00FF, 64'hFFF0_FFFF_8000_FFFF, 1, 0, 0, 0};
        vecs[5]  = '{ALU_XOR,      64'hF0F0_1234_0000_FFFF, 64'h0FF0_FFFF_8000_00FF, 64'hFF00_EDCB_8000_FF00, 1, 0, 0, 0};
        vecs[6]  = '{ALU_PASS_B,   64'hF0F0_1234_0000_FFFF, 64'h0FF0_FFFF_8000_00FF, 64'h0FF0_FFFF_8000_00FF, 0, 0, 0, 0};
        vecs[7]  = '{ALU_ADD,      64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 0, 1, 0, 1};
        vecs[8]  = '{ALU_SUBTRACT, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1};
        vecs[9]  = '{3'b111,       64'hF0F0_1234_0000_FFFF, 64'h0FF0_FFFF_8000_00FF, 64'h0, 0, 1, 0, 0};
        vecs[10] = '{3'b001,       64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 0, 1, 0, 0};

        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset s%0d in_ready", lat[d]), 64'(in_ready[d]), 64'd0);
            chk($sformatf("reset s%0d out_valid", lat[d]), 64'(out_valid[d]), 64'd0);
            chk($sformatf("reset s%0d result", lat[d]), res[d], 64'd0);
            chk($sformatf("reset s%0d zero", lat[d]), 64'(zro[d]), 64'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 11; i++)
                do_op(d, $sformatf("lat%0d v%0d", lat[d], i), vecs[i].c, vecs[i].a, vecs[i].b,
                      vecs[i].r, vecs[i].n, vecs[i].z, vecs[i].v, vecs[i].co);

        // Backpressure: hold in DONE while new operands are offered.
        @(negedge clk);
        A = 64'd3; B = 64'd4; ctrl = ALU_ADD; in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("bp out_valid", 64'(out_valid[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = 64'(i + 100); B = 64'd9; ctrl = ALU_SUBTRACT; in_valid[0] = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d out_valid", i), 64'(out_valid[0]), 64'd1);
            chk($sformatf("bp%0d in_ready", i), 64'(in_ready[0]), 64'd0);
            chk($sformatf("bp%0d result", i), res[0], 64'd7);
            chk($sformatf("bp%0d flags", i), {60'd0, neg[0], zro[0], ovf[0], cout[0]}, 64'd0);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        chk("bp release out_valid", 64'(out_valid[0]), 64'd0);
        chk("bp release in_ready", 64'(in_ready[0]), 64'd1);
        do_op(0, "bp next", ALU_ADD, 64'd1, 64'd2, 64'd3, 0, 0, 0, 0);

        // Asynchronous reset during digit 3 of a subtract.
        @(negedge clk);
        A = 64'h0123_4567_89AB_CDEF; B = 64'h0; ctrl = ALU_SUBTRACT; in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst mid result", res[0], 64'd0);
        chk("rst mid out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst mid in_ready", 64'(in_ready[0]), 64'd0);
        chk("rst mid flags", {60'd0, neg[0], zro[0], ovf[0], cout[0]}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst release in_ready", 64'(in_ready[0]), 64'd1);
        do_op(0, "post-rst 1+1", ALU_ADD, 64'd1, 64'd1, 64'd2, 0, 0, 0, 0);
        do_op(0, "post-rst 0+0", ALU_ADD, 64'd0, 64'd0, 64'd0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
